// File: rtl/amba_apb_master_pkg.sv
// Shared types and constants for the APB initiator that produces the core's ambain byte.
package amba_apb_master_pkg;

  localparam int APB_ADDR_W  = 6;
  localparam int APB_DATA_W  = 8;
  localparam int APB_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/amba_apb_master_if.sv
// Core-side request/response and APB bus signals of the initiator, bundled with
// a master view (the initiator) and a slave view (core controller plus peripheral).
interface amba_apb_master_if
  import amba_apb_master_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] ambain;
  logic              rsp_valid;
  logic              rsp_err;

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, ambain, rsp_valid, rsp_err,
           paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, ambain, rsp_valid, rsp_err,
           paddr, psel, penable, pwrite, pwdata
  );

endinterface

// File: rtl/apb_wait_counter.sv
// ACCESS-phase wait-state counter; limit_o flags the wait cycle that reaches LIMIT.
// Only built when APB_TIMEOUT_EN is defined.
`ifdef APB_TIMEOUT_EN
module apb_wait_counter #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic limit_o
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;

  assign limit_o = inc_i && (cnt_q == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !limit_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/amba_apb_master.sv
// APB initiator: 8-bit read/write transfers for the core, last good read held on ambain.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT wait cycles with an error response.
module amba_apb_master
  import amba_apb_master_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = APB_TIMEOUT
`endif
) (
  input logic                clk,
  input logic                rst,
  amba_apb_master_if.master  bus
);

  apb_state_e        state_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] ambain_q;
  logic              pwrite_q;
  logic              psel_q;
  logic              penable_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              wait_limit;

`ifdef APB_TIMEOUT_EN
  apb_wait_counter #(.LIMIT(TIMEOUT)) u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_q == SETUP),
    .inc_i   ((state_q == ACCESS) && !bus.pready),
    .limit_o (wait_limit)
  );
`else
  assign wait_limit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      ambain_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            paddr_q     <= bus.req_addr;
            pwrite_q    <= bus.req_write;
            pwdata_q    <= bus.req_wdata;
            psel_q      <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // pready has priority over a timeout landing in the same cycle
          if (bus.pready) begin
            if (!pwrite_q && !bus.pslverr) begin
              ambain_q <= bus.prdata;
            end
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus.pslverr;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else if (wait_limit) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.ambain    = ambain_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.paddr     = paddr_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_amba_apb_master.sv
// Self-checking bench for amba_apb_master: scoreboard of expected responses,
// a wait-state-programmable peripheral model and cycle-level protocol checks.
module tb_amba_apb_master;
  import amba_apb_master_pkg::*;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         slv_waits = 0;
  int         acc_cnt = 0;
  logic       err_en = 1'b0;
  logic [5:0] err_addr = '0;
  logic [7:0] slv_mem [64];
  logic [7:0] model_ambain = '0;
  exp_t       sb_q [$];
  exp_t       mon_e;

  amba_apb_master_if bus_if ();

  amba_apb_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign bus_if.prdata  = slv_mem[bus_if.paddr];
  assign bus_if.pslverr = err_en && (bus_if.paddr == err_addr);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // peripheral: inserts slv_waits wait states per ACCESS
  always @(negedge clk) begin
    if (!rst && bus_if.psel && bus_if.penable) begin
      bus_if.pready = (acc_cnt >= slv_waits);
      acc_cnt++;
    end else begin
      bus_if.pready = 1'b0;
      acc_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst && bus_if.rsp_valid) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_rsp_err", 32'(bus_if.rsp_err), 32'(mon_e.err));
        check("sb_ambain", 32'(bus_if.ambain), 32'(mon_e.data));
      end
    end
  end

  task automatic push_exp(input logic w, input logic [5:0] a, input logic tmo);
    exp_t e;
    logic err;
    err = tmo || (err_en && (a == err_addr));
    if (!w && !err) model_ambain = slv_mem[a];
    e.err  = err;
    e.data = model_ambain;
    sb_q.push_back(e);
  endtask

  task automatic run_xfer(input logic w, input logic [5:0] a, input logic [7:0] d,
                          input int waits, input logic tmo);
    int acc;
    int lat;
    int exp_acc;
    exp_acc = tmo ? APB_TIMEOUT : waits + 1;
    push_exp(w, a, tmo);
    slv_waits = waits;
    bus_if.req_valid = 1'b1;
    bus_if.req_write = w;
    bus_if.req_addr  = a;
    bus_if.req_wdata = d;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    bus_if.req_write = ~w;
    bus_if.req_addr  = ~a;
    bus_if.req_wdata = ~d;
    check("setup_psel", 32'(bus_if.psel), 32'd1);
    check("setup_penable", 32'(bus_if.penable), 32'd0);
    check("setup_ready", 32'(bus_if.req_ready), 32'd0);
    check("setup_paddr", 32'(bus_if.paddr), 32'(a));
    acc = 0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus_if.rsp_valid) break;
      if (bus_if.psel && bus_if.penable) acc++;
      check("hold_paddr", 32'(bus_if.paddr), 32'(a));
      check("hold_pwrite", 32'(bus_if.pwrite), 32'(w));
      check("hold_pwdata", 32'(bus_if.pwdata), 32'(d));
    end
    check("rsp_seen", 32'(bus_if.rsp_valid), 32'd1);
    check("access_cycles", 32'(acc), 32'(exp_acc));
    check("latency", 32'(lat), 32'(exp_acc + 1));
    check("done_ready", 32'(bus_if.req_ready), 32'd1);
    check("done_psel", 32'(bus_if.psel), 32'd0);
    check("done_penable", 32'(bus_if.penable), 32'd0);
    check("done_paddr_held", 32'(bus_if.paddr), 32'(a));
    @(posedge clk); #1;
    check("rsp_once", 32'(bus_if.rsp_valid), 32'd0);
  endtask

  task automatic wait_rsp(input string tag, output int t);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus_if.rsp_valid) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int t1;
    int t2;
    for (int i = 0; i < 64; i++) slv_mem[i] = 8'(i * 3 + 1);
    slv_mem[5]     = 8'hA5;
    slv_mem[1]     = 8'h11;
    slv_mem[2]     = 8'h22;
    slv_mem[6'h10] = 8'hFF;
    slv_mem[8]     = 8'h88;
    bus_if.req_valid = 1'b0;
    bus_if.req_write = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.req_wdata = '0;

    #12;
    check("rst_psel", 32'(bus_if.psel), 32'd0);
    check("rst_penable", 32'(bus_if.penable), 32'd0);
    check("rst_ready", 32'(bus_if.req_ready), 32'd1);
    check("rst_ambain", 32'(bus_if.ambain), 32'd0);
    check("rst_paddr", 32'(bus_if.paddr), 32'd0);
    check("rst_pwdata", 32'(bus_if.pwdata), 32'd0);
    check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_xfer(1'b0, 6'h05, 8'h00, 0, 1'b0);
    check("t1_ambain", 32'(bus_if.ambain), 32'hA5);

    run_xfer(1'b1, 6'h3F, 8'h5A, 3, 1'b0);
    check("t2_ambain", 32'(bus_if.ambain), 32'hA5);

    err_en   = 1'b1;
    err_addr = 6'h10;
    run_xfer(1'b0, 6'h10, 8'h00, 0, 1'b0);
    check("t3_ambain", 32'(bus_if.ambain), 32'hA5);
    err_en = 1'b0;

    // back-to-back reads with req_valid held across the response cycle
    slv_waits = 0;
    push_exp(1'b0, 6'h01, 1'b0);
    push_exp(1'b0, 6'h02, 1'b0);
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b0;
    bus_if.req_addr  = 6'h01;
    @(posedge clk); #1;
    bus_if.req_addr = 6'h02;
    wait_rsp("b2b_first_timeout", t1);
    check("b2b_first_ambain", 32'(bus_if.ambain), 32'h11);
    check("b2b_first_ready", 32'(bus_if.req_ready), 32'd1);
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    check("b2b_accept_psel", 32'(bus_if.psel), 32'd1);
    check("b2b_accept_paddr", 32'(bus_if.paddr), 32'h02);
    wait_rsp("b2b_second_timeout", t2);
    check("b2b_spacing", 32'(t2 - t1), 32'd3);
    check("b2b_second_ambain", 32'(bus_if.ambain), 32'h22);
    @(posedge clk); #1;

    // reset asserted mid-ACCESS with the peripheral stalling
    slv_waits = 1000;
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = 6'h07;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_access", 32'(bus_if.psel && bus_if.penable), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_psel", 32'(bus_if.psel), 32'd0);
    check("arst_penable", 32'(bus_if.penable), 32'd0);
    check("arst_ambain", 32'(bus_if.ambain), 32'd0);
    check("arst_ready", 32'(bus_if.req_ready), 32'd1);
    model_ambain = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("arst_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
      check("arst_idle_psel", 32'(bus_if.psel), 32'd0);
    end

`ifdef APB_TIMEOUT_EN
    run_xfer(1'b0, 6'h08, 8'h00, 1000, 1'b1);
    check("tmo_ambain", 32'(bus_if.ambain), 32'd0);
`endif

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
